// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter that serialises single-beat requests from NUM_REQ clients onto one
// axi4_lite_master command port. Define ARB_TIMEOUT_EN to add a bounded WAIT with sticky timeout_err.
module axi4_lite_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STROB_WIDTH    = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*STROB_WIDTH-1:0]  req_strb,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            m_write_en,
   output logic                            m_read_en,
   output logic [ADDR_WIDTH-1:0]           m_write_addr,
   output logic [ADDR_WIDTH-1:0]           m_read_addr,
   output logic [DATA_WIDTH-1:0]           m_write_data,
   output logic [STROB_WIDTH-1:0]          m_strobe,
   input  logic [DATA_WIDTH-1:0]           m_read_data,
   input  logic [1:0]                      m_write_resp,
   input  logic [1:0]                      m_read_resp,
   input  logic                            m_write_done,
   input  logic                            m_read_done,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            timeout_err
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                 state_r, state_s;
   logic [IDW-1:0]         last_r, grant_r, winner_s;
   logic                   found_s, done_s, expire_s, cmd_write_r;
   logic [NUM_REQ-1:0]     req_ready_r, rsp_valid_r;
   logic                   m_write_en_r, m_read_en_r, busy_r;
   logic [ADDR_WIDTH-1:0]  m_write_addr_r, m_read_addr_r;
   logic [DATA_WIDTH-1:0]  m_write_data_r, rsp_rdata_r;
   logic [STROB_WIDTH-1:0] m_strobe_r;
   logic [1:0]             rsp_resp_r;

   // First set bit searching upward from last+1, wrapping; MSB of the result flags "found".
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
      logic [IDW:0] pick;
      int           idx;
      pick = {(IDW+1){1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!pick[IDW] && valid[idx]) begin
            pick = {1'b1, IDW'(idx)};
         end
      end
      return pick;
   endfunction

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDW-1:0] idx);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Arbitration winner and the done pulse that matches the latched command type
   always_comb begin
      {found_s, winner_s} = rr_pick(req_valid, last_r);
      done_s = cmd_write_r ? m_write_done : m_read_done;
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (found_s) state_s = ISSUE;
            else         state_s = IDLE;
         end
         ISSUE: state_s = WAIT;
         WAIT: begin
            if (done_s || expire_s) state_s = RESP;
            else                    state_s = WAIT;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_r <= IDLE;
      else          state_r <= state_s;
   end

   // Command latch, one-cycle pulses and response capture
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         last_r         <= IDW'(NUM_REQ - 1);
         grant_r        <= {IDW{1'b0}};
         cmd_write_r    <= 1'b0;
         req_ready_r    <= {NUM_REQ{1'b0}};
         rsp_valid_r    <= {NUM_REQ{1'b0}};
         m_write_en_r   <= 1'b0;
         m_read_en_r    <= 1'b0;
         busy_r         <= 1'b0;
         m_write_addr_r <= {ADDR_WIDTH{1'b0}};
         m_read_addr_r  <= {ADDR_WIDTH{1'b0}};
         m_write_data_r <= {DATA_WIDTH{1'b0}};
         m_strobe_r     <= {STROB_WIDTH{1'b0}};
         rsp_rdata_r    <= {DATA_WIDTH{1'b0}};
         rsp_resp_r     <= 2'b00;
      end else begin
         req_ready_r  <= {NUM_REQ{1'b0}};
         rsp_valid_r  <= {NUM_REQ{1'b0}};
         m_write_en_r <= 1'b0;
         m_read_en_r  <= 1'b0;
         busy_r       <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  grant_r     <= winner_s;
                  cmd_write_r <= req_write[winner_s];
                  req_ready_r <= one_hot(winner_s);
                  if (req_write[winner_s]) begin
                     m_write_en_r   <= 1'b1;
                     m_write_addr_r <= req_addr[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
                     m_write_data_r <= req_wdata[winner_s*DATA_WIDTH +: DATA_WIDTH];
                     m_strobe_r     <= req_strb[winner_s*STROB_WIDTH +: STROB_WIDTH];
                  end else begin
                     m_read_en_r    <= 1'b1;
                     m_read_addr_r  <= req_addr[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
                  end
               end
            end
            WAIT: begin
               // A matching done wins over a watchdog expiry in the same cycle.
               if (done_s) begin
                  rsp_valid_r <= one_hot(grant_r);
                  rsp_rdata_r <= cmd_write_r ? {DATA_WIDTH{1'b0}} : m_read_data;
                  rsp_resp_r  <= cmd_write_r ? m_write_resp : m_read_resp;
               end else if (expire_s) begin
                  rsp_valid_r <= one_hot(grant_r);
                  rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                  rsp_resp_r  <= 2'b10;
               end
            end
            RESP:    last_r <= grant_r;
            default: ;
         endcase
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_r;
   logic             timeout_err_r;

   assign expire_s = (state_r == WAIT) && !done_s &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

   // WAIT-cycle counter and sticky timeout flag
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wait_cnt_r    <= {CNT_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         if (state_r == ISSUE)     wait_cnt_r <= {CNT_W{1'b0}};
         else if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + CNT_W'(1);
         if (expire_s)             timeout_err_r <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_r;
`else
   assign expire_s    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign req_ready    = req_ready_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_rdata    = rsp_rdata_r;
   assign rsp_resp     = rsp_resp_r;
   assign m_write_en   = m_write_en_r;
   assign m_read_en    = m_read_en_r;
   assign m_write_addr = m_write_addr_r;
   assign m_read_addr  = m_read_addr_r;
   assign m_write_data = m_write_data_r;
   assign m_strobe     = m_strobe_r;
   assign busy         = busy_r;
   assign grant_id     = grant_r;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Randomised self-checking bench: transaction-level reference model compared every cycle,
// plus directed write/read/fairness/reset (and timeout when ARB_TIMEOUT_EN) literal checks.
module tb_axi4_lite_req_arbiter;
   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_write = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR*SW-1:0] req_strb = '0;
   logic [NR-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic [1:0]       rsp_resp;
   logic             m_write_en, m_read_en;
   logic [AW-1:0]    m_write_addr, m_read_addr;
   logic [DW-1:0]    m_write_data;
   logic [SW-1:0]    m_strobe;
   logic [DW-1:0]    m_read_data = '0;
   logic [1:0]       m_write_resp = '0;
   logic [1:0]       m_read_resp = '0;
   logic             m_write_done = 1'b0;
   logic             m_read_done = 1'b0;
   logic             busy;
   logic [1:0]       grant_id;
   logic             timeout_err;

   axi4_lite_req_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_write_en(m_write_en), .m_read_en(m_read_en),
      .m_write_addr(m_write_addr), .m_read_addr(m_read_addr),
      .m_write_data(m_write_data), .m_strobe(m_strobe),
      .m_read_data(m_read_data), .m_write_resp(m_write_resp), .m_read_resp(m_read_resp),
      .m_write_done(m_write_done), .m_read_done(m_read_done),
      .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
   );

   always #5 ACLK = ~ACLK;

   int vectors = 0;
   int miscompares = 0;

   // master BFM controls
   int          bfm_lat = 0;      // 0 = random 1..6
   int          bfm_wrong = 0;    // 0 none, 1 every non-final WAIT cycle, 2 random
   bit          bfm_silent = 1'b0;
   bit          bfm_directed = 1'b0;
   logic [31:0] bfm_rdata = '0;
   logic [1:0]  bfm_resp = '0;

   // reference model state and expected outputs
   bit          md_busy = 1'b0;
   int          md_stage = 0;     // 0 command issued, 1 awaiting master, 2 responding
   int          md_owner = 0;
   int          md_last = NR - 1;
   int          md_wait = 0;
   bit          md_write = 1'b0;
   logic        e_busy = 1'b0, e_wen = 1'b0, e_ren = 1'b0, e_tmo = 1'b0;
   logic [1:0]  e_grant = '0, e_resp = '0;
   logic [NR-1:0] e_ready = '0, e_rsp = '0;
   logic [31:0] e_wa = '0, e_wd = '0, e_ra = '0, e_rdata = '0;
   logic [3:0]  e_strb = '0;

   int          obs_grants[$];
   bit [NR-1:0] outst = '0;

   // directed-transaction captures
   logic [NR-1:0] cap_ready, cap_rsp;
   logic        cap_wen, cap_ren;
   logic [31:0] cap_wa, cap_wd, cap_ra, cap_rdata;
   logic [3:0]  cap_st;
   logic [1:0]  cap_resp;
   int          cap_lat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction at a time, judged from inputs only.
   initial begin : model
      bit found;
      int c;
      forever begin
         @(posedge ACLK or negedge ARESETn);
         if (!ARESETn) begin
            md_busy = 1'b0; md_last = NR - 1; md_owner = 0;
            e_busy = 0; e_grant = 0; e_ready = 0; e_rsp = 0; e_wen = 0; e_ren = 0;
            e_wa = 0; e_wd = 0; e_strb = 0; e_ra = 0; e_rdata = 0; e_resp = 0; e_tmo = 0;
         end else begin
            e_ready = '0; e_rsp = '0; e_wen = 1'b0; e_ren = 1'b0;
            if (!md_busy) begin
               found = 1'b0;
               for (int k = 1; k <= NR; k++) begin
                  c = (md_last + k) % NR;
                  if (!found && req_valid[c]) begin found = 1'b1; md_owner = c; end
               end
               if (found) begin
                  md_busy = 1'b1; md_stage = 0; md_write = req_write[md_owner];
                  e_grant = 2'(md_owner);
                  e_ready[md_owner] = 1'b1;
                  if (md_write) begin
                     e_wen = 1'b1;
                     e_wa = req_addr[md_owner*AW +: AW];
                     e_wd = req_wdata[md_owner*DW +: DW];
                     e_strb = req_strb[md_owner*SW +: SW];
                  end else begin
                     e_ren = 1'b1;
                     e_ra = req_addr[md_owner*AW +: AW];
                  end
               end
            end else if (md_stage == 0) begin
               md_stage = 1; md_wait = 0;
            end else if (md_stage == 1) begin
               md_wait++;
               if (md_write ? m_write_done : m_read_done) begin
                  md_stage = 2;
                  e_rsp[md_owner] = 1'b1;
                  e_rdata = md_write ? 32'h0 : m_read_data;
                  e_resp = md_write ? m_write_resp : m_read_resp;
               end
`ifdef ARB_TIMEOUT_EN
               else if (md_wait == TO) begin
                  md_stage = 2;
                  e_rsp[md_owner] = 1'b1;
                  e_rdata = 32'h0; e_resp = 2'b10; e_tmo = 1'b1;
               end
`endif
            end else begin
               md_last = md_owner; md_busy = 1'b0;
            end
            e_busy = md_busy;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   initial begin : compare
      forever begin
         @(negedge ACLK);
         chk("busy", 64'(busy), 64'(e_busy));
         chk("grant_id", 64'(grant_id), 64'(e_grant));
         chk("req_ready", 64'(req_ready), 64'(e_ready));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
         chk("m_write_en", 64'(m_write_en), 64'(e_wen));
         chk("m_read_en", 64'(m_read_en), 64'(e_ren));
         chk("m_write_addr", 64'(m_write_addr), 64'(e_wa));
         chk("m_write_data", 64'(m_write_data), 64'(e_wd));
         chk("m_strobe", 64'(m_strobe), 64'(e_strb));
         chk("m_read_addr", 64'(m_read_addr), 64'(e_ra));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
         chk("rsp_resp", 64'(rsp_resp), 64'(e_resp));
         chk("timeout_err", 64'(timeout_err), 64'(e_tmo));
         if (req_ready != '0) obs_grants.push_back(int'(grant_id));
      end
   end

   // Master BFM: answers each command after a latency, optionally with wrong-type dones
   initial begin : bfm
      int cnt;
      bit pw;
      cnt = 0; pw = 1'b0;
      forever begin
         @(negedge ACLK);
         m_write_done = 1'b0; m_read_done = 1'b0;
         if (!ARESETn) begin
            cnt = 0;
         end else if (m_write_en || m_read_en) begin
            pw = m_write_en;
            cnt = (bfm_lat > 0) ? bfm_lat : int'($urandom_range(1, 6));
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               if (!bfm_silent) begin
                  if (pw) begin
                     m_write_done = 1'b1;
                     m_write_resp = bfm_directed ? bfm_resp : 2'($urandom);
                  end else begin
                     m_read_done = 1'b1;
                     m_read_data = bfm_directed ? bfm_rdata : $urandom;
                     m_read_resp = bfm_directed ? bfm_resp : 2'($urandom);
                  end
               end
            end else if (bfm_wrong == 1 || (bfm_wrong == 2 && $urandom_range(0, 2) == 0)) begin
               if (pw) begin
                  m_read_done = 1'b1; m_read_data = $urandom; m_read_resp = 2'($urandom);
               end else begin
                  m_write_done = 1'b1; m_write_resp = 2'($urandom);
               end
            end
         end
      end
   end

   task automatic requesters();
      for (int i = 0; i < NR; i++) begin
         if (rsp_valid[i]) outst[i] = 1'b0;
         if (req_valid[i] && req_ready[i]) begin
            req_valid[i] = 1'b0; outst[i] = 1'b1;
         end else if (req_valid[i]) begin
            if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
         end else if (!outst[i] && $urandom_range(0, 3) == 0) begin
            req_write[i] = 1'($urandom);
            req_addr[i*AW +: AW] = $urandom;
            req_wdata[i*DW +: DW] = $urandom;
            req_strb[i*SW +: SW] = 4'($urandom);
            req_valid[i] = 1'b1;
         end
      end
   endtask

   task automatic run_txn(input int i);
      int cyc, rdy_cyc;
      bit got_rdy, got_rsp;
      cyc = 0; rdy_cyc = 0; got_rdy = 1'b0; got_rsp = 1'b0; cap_lat = -1;
      while (!got_rsp && cyc < 60) begin
         @(negedge ACLK);
         cyc++;
         if (!got_rdy && req_ready[i]) begin
            got_rdy = 1'b1; rdy_cyc = cyc;
            cap_ready = req_ready; cap_wen = m_write_en; cap_ren = m_read_en;
            cap_wa = m_write_addr; cap_wd = m_write_data; cap_st = m_strobe; cap_ra = m_read_addr;
            req_valid[i] = 1'b0;
         end else if (got_rdy && rsp_valid != '0) begin
            got_rsp = 1'b1; cap_lat = cyc - rdy_cyc;
            cap_rsp = rsp_valid; cap_rdata = rsp_rdata; cap_resp = rsp_resp;
         end
      end
      if (!got_rsp) begin
         vectors++; miscompares++;
         $display("FAIL txn_bound req %0d: got no response expected one within 60 cycles", i);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge ACLK);
      req_valid = '0;
      while (busy && n < 100) begin
         @(negedge ACLK);
         n++;
      end
      chk("drain_idle", 64'(busy), 64'd0);
      outst = '0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish expected one before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n0, n;
      repeat (3) @(negedge ACLK);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_grant", 64'(grant_id), 64'd0);
      ARESETn = 1'b1;
      repeat (2) @(negedge ACLK);

      // single write from requester 2, master answers after 3 cycles
      bfm_lat = 3; bfm_directed = 1'b1; bfm_resp = 2'b00; bfm_rdata = 32'h0;
      req_write[2] = 1'b1; req_addr[2*AW +: AW] = 32'h10;
      req_wdata[2*DW +: DW] = 32'hDEADBEEF; req_strb[2*SW +: SW] = 4'hF;
      req_valid[2] = 1'b1;
      run_txn(2);
      chk("wr_ready", 64'(cap_ready), 64'h4);
      chk("wr_wen", 64'(cap_wen), 64'd1);
      chk("wr_ren", 64'(cap_ren), 64'd0);
      chk("wr_addr", 64'(cap_wa), 64'h10);
      chk("wr_data", 64'(cap_wd), 64'hDEADBEEF);
      chk("wr_strb", 64'(cap_st), 64'hF);
      chk("wr_rsp", 64'(cap_rsp), 64'h4);
      chk("wr_rdata", 64'(cap_rdata), 64'h0);
      chk("wr_resp", 64'(cap_resp), 64'h0);
      chk("wr_latency", 64'(cap_lat), 64'd4);

      // single read from requester 1 with wrong-type dones during WAIT
      bfm_lat = 4; bfm_wrong = 1; bfm_rdata = 32'h12345678;
      req_write[1] = 1'b0; req_addr[1*AW +: AW] = 32'h20; req_valid[1] = 1'b1;
      run_txn(1);
      chk("rd_ready", 64'(cap_ready), 64'h2);
      chk("rd_ren", 64'(cap_ren), 64'd1);
      chk("rd_wen", 64'(cap_wen), 64'd0);
      chk("rd_addr", 64'(cap_ra), 64'h20);
      chk("rd_rsp", 64'(cap_rsp), 64'h2);
      chk("rd_rdata", 64'(cap_rdata), 64'h12345678);
      chk("rd_resp", 64'(cap_resp), 64'h0);
      chk("rd_latency", 64'(cap_lat), 64'd5);

      // randomised traffic with withdrawals and random wrong-type dones
      bfm_lat = 0; bfm_wrong = 2; bfm_directed = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         @(negedge ACLK);
         requesters();
      end
      drain();

      // asynchronous reset while a read is in WAIT
      bfm_lat = 10; bfm_wrong = 0;
      req_write[3] = 1'b0; req_addr[3*AW +: AW] = $urandom; req_valid[3] = 1'b1;
      n = 0;
      while (!req_ready[3] && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("rst_mid_granted", 64'(req_ready[3]), 64'd1);
      req_valid[3] = 1'b0;
      repeat (3) @(negedge ACLK);
      #1 ARESETn = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_rsp", 64'(rsp_valid), 64'd0);
      chk("rst_mid_ren", 64'(m_read_en), 64'd0);
      chk("rst_mid_raddr", 64'(m_read_addr), 64'd0);
      chk("rst_mid_grant", 64'(grant_id), 64'd0);
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;

      // fairness: all requesters held valid, expect 0,1,2,3,0,1,2,3
      bfm_lat = 0; bfm_wrong = 2;
      for (int i = 0; i < NR; i++) begin
         req_write[i] = 1'($urandom);
         req_addr[i*AW +: AW] = $urandom;
         req_wdata[i*DW +: DW] = $urandom;
         req_strb[i*SW +: SW] = 4'($urandom);
      end
      n0 = obs_grants.size();
      req_valid = '1;
      n = 0;
      while (obs_grants.size() < n0 + 8 && n < 300) begin
         @(negedge ACLK);
         n++;
      end
      if (obs_grants.size() < n0 + 8) begin
         vectors++; miscompares++;
         $display("FAIL fair_bound: got %0d grants expected 8", obs_grants.size() - n0);
      end else begin
         for (int k = 0; k < 8; k++) chk("fair_grant", 64'(obs_grants[n0+k]), 64'(k % NR));
      end
      drain();

`ifdef ARB_TIMEOUT_EN
      // silent master: watchdog must answer after TO WAIT cycles with SLVERR
      bfm_silent = 1'b1; bfm_lat = 3; bfm_wrong = 0;
      req_write[0] = 1'b0; req_addr[0 +: AW] = 32'h40; req_valid[0] = 1'b1;
      run_txn(0);
      chk("tmo_latency", 64'(cap_lat), 64'(TO + 1));
      chk("tmo_rsp", 64'(cap_rsp), 64'h1);
      chk("tmo_resp", 64'(cap_resp), 64'h2);
      chk("tmo_rdata", 64'(cap_rdata), 64'h0);
      repeat (5) @(negedge ACLK);
      chk("tmo_sticky", 64'(timeout_err), 64'd1);
      bfm_silent = 1'b0;
`endif

      repeat (2) @(negedge ACLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
